// File: rtl/sdpram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sdpram_fifo_pkg
// Shared helpers for the SDPRAM-backed synchronous FIFO controller:
//   clog2       - ceiling log2 of a positive integer
//   fifo_depth  - number of RAM words for a given address width
//   cnt_width   - occupancy counter / pointer width (one wrap bit above the
//                 RAM address, so that 0..DEPTH is representable)
// No ports; imported by sdpram_fifo_ptr and sdpram_sync_fifo_ctrl.
// -----------------------------------------------------------------------------
package sdpram_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sdpram_fifo_ptr.sv
// -----------------------------------------------------------------------------
// sdpram_fifo_ptr
// Binary FIFO pointer, ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address
// the RAM, the MSB is the wrap bit; the pointer wraps naturally at 2*DEPTH.
// Ports:
//   clk      in   1               rising-edge clock
//   rst      in   1               asynchronous, active-high reset (ptr -> 0)
//   inc      in   1               advance the pointer on the next edge
//   ptr      out  ADDR_WIDTH+1    registered pointer value
//   ptr_nxt  out  ADDR_WIDTH+1    value ptr takes on the next edge
// -----------------------------------------------------------------------------
module sdpram_fifo_ptr
    import sdpram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   ptr,
    output logic [ADDR_WIDTH:0]   ptr_nxt
);

    // ptr_nxt is exported so the parent can derive next-cycle occupancy
    // without duplicating the increment.
    assign ptr_nxt = ptr + {{ADDR_WIDTH{1'b0}}, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/sdpram_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdpram_sync_fifo_ctrl
// Single-clock FIFO controller sequencing one external distributed SDPRAM
// (no output register, same clock on both ports). Owns the write/read
// pointers, occupancy count and flags, drives the RAM address buses and
// registers the RAM's combinational read data (read latency 1).
//
// Optional feature macro: SDPRAM_FIFO_ERR_FLAGS_EN
//   defined   -> adds err_clr / overflow / underflow (sticky error flags)
//   undefined -> no error logic; rejected requests are silently dropped
//
// Ports:
//   clk           in   1             rising-edge clock
//   rst           in   1             asynchronous, active-high reset
//   wr_en         in   1             write request
//   wr_data       in   DATA_WIDTH    write word
//   full          out  1             count == DEPTH
//   almost_full   out  1             count >= AF_LEVEL
//   rd_en         in   1             read request
//   rd_data       out  DATA_WIDTH    registered read word
//   rd_valid      out  1             rd_data valid this cycle
//   empty         out  1             count == 0
//   almost_empty  out  1             count <= AE_LEVEL
//   count         out  ADDR_WIDTH+1  occupancy 0..DEPTH
//   ram_wr_en     out  1             RAM write enable
//   ram_wr_addr   out  ADDR_WIDTH    RAM write address
//   ram_wr_data   out  DATA_WIDTH    RAM write data
//   ram_rd_addr   out  ADDR_WIDTH    RAM read address
//   ram_rd_data   in   DATA_WIDTH    RAM read data (combinational)
//   err_clr       in   1             (macro) clear sticky error flags
//   overflow      out  1             (macro) write attempted while full
//   underflow     out  1             (macro) read attempted while empty
// -----------------------------------------------------------------------------
module sdpram_sync_fifo_ctrl
    import sdpram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef SDPRAM_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int                CNT_W   = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_LEVEL);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_level_check
        $error("sdpram_sync_fifo_ctrl: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic              wr_acc;
    logic              rd_acc;
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic              vld_p1;

    // Acceptance is judged only on registered flags, so a read on a full
    // FIFO frees no room for a same-cycle write, and a write on an empty
    // FIFO never falls through to a same-cycle read.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    sdpram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (wr_acc),
        .ptr     (wr_ptr),
        .ptr_nxt (wr_ptr_nxt)
    );

    sdpram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (rd_acc),
        .ptr     (rd_ptr),
        .ptr_nxt (rd_ptr_nxt)
    );

    // Pointer difference modulo 2*DEPTH is the exact occupancy 0..DEPTH.
    assign cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;

    assign ram_wr_en   = wr_acc;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = wr_data;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // ---- stage p1: occupancy, flags and registered read data ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1       <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            vld_p1       <= 1'b0;
            rd_data_p1   <= '0;
        end else begin
            cnt_p1       <= cnt_nxt;
            full         <= (cnt_nxt == DEPTH_C);
            almost_full  <= (cnt_nxt >= AF_C);
            empty        <= (cnt_nxt == '0);
            almost_empty <= (cnt_nxt <= AE_C);
            vld_p1       <= rd_acc;
            if (rd_acc) begin
                rd_data_p1 <= ram_rd_data;
            end
        end
    end

    assign count    = cnt_p1;
    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;

`ifdef SDPRAM_FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdpram_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdpram_sync_fifo_ctrl
// Self-checking bench: a behavioural RAM and a queue-based FIFO reference
// model; every cycle the DUT outputs are compared against the model.
// Error-flag checks are active when SDPRAM_FIFO_ERR_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_sdpram_sync_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          err_clr;
`ifdef SDPRAM_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    sdpram_sync_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data)
`ifdef SDPRAM_FIFO_ERR_FLAGS_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // Behavioural distributed RAM: synchronous write, combinational read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = mem[ram_rd_addr];

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_udf;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},        32'(count),        32'(sz));
        chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rd_valid));
        chk({tag, ".rd_data"},      32'(rd_data),      32'(m_rd_data));
`ifdef SDPRAM_FIFO_ERR_FLAGS_EN
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_udf));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    // One clock cycle: apply requests, advance the model by the FIFO rules
    // using the pre-edge occupancy, then compare.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic ec);
        int  pre;
        logic wacc, racc;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = ec;
        @(posedge clk);
        #1;
        pre  = q.size();
        wacc = w && (pre < DEPTH);
        racc = r && (pre > 0);
        if (racc) begin
            m_rd_data  = q.pop_front();
            m_rd_valid = 1'b1;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (wacc) q.push_back(d);
        if (w && pre == DEPTH) m_ovf = 1'b1;
        else if (ec)           m_ovf = 1'b0;
        if (r && pre == 0)     m_udf = 1'b1;
        else if (ec)           m_udf = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: fill with 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill_full_direct", 32'(full), 32'd1);
        chk("fill_count_direct", 32'(count), 32'd16);

        // 2: overflow attempt, then drain in order
        step("ovf_write", 1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_order", 32'(rd_data), 32'(i));
        end

        // 3: underflow attempt, then clear
        step("udf_read", 1'b0, 8'h00, 1'b1, 1'b0);
        step("err_clr",  1'b0, 8'h00, 1'b0, 1'b1);
        step("idle",     1'b0, 8'h00, 1'b0, 1'b0);

        // 4: full with simultaneous write/read
        for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, DW'($urandom), 1'b0, 1'b0);
        step("full_both", 1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_both_count", 32'(count), 32'd15);
        for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("drain2_end", 1'b0, 8'h00, 1'b0, 1'b1);

        // 5: empty with simultaneous write/read
        step("empty_both", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_both_valid", 32'(rd_valid), 32'd0);
        step("read_77", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("read_77_data", 32'(rd_data), 32'h77);

        // 6: random traffic with an asynchronous reset mid-burst
        for (int i = 0; i < 80; i++) begin
            if (i == 40) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs("rst_async");
                wr_en = 1'b0;
                rd_en = 1'b0;
                @(posedge clk);
                #1;
                check_outputs("rst_hold");
                rst = 1'b0;
            end
            // Write-heavy first half of each segment, read-heavy second.
            step("rand",
                 ($urandom_range(0, 99) < (((i % 40) < 20) ? 75 : 30)),
                 DW'($urandom),
                 ($urandom_range(0, 99) < (((i % 40) < 20) ? 30 : 75)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
